// File: rtl/issue_scheduler.sv
// N-wide in-order issue scheduler: fetch queue, hazard-aware group formation, registered issue stage.
// Optional statistics counters are enabled by defining ISSUE_SCHED_STATS_EN.
module issue_scheduler #(
  parameter int ISSUE_WIDTH = 2,
  parameter int QDEPTH      = 8,
  parameter int MAX_LS      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [ISSUE_WIDTH-1:0]   fetch_mask,
  input  logic [64*ISSUE_WIDTH-1:0] fetch_data,
  output logic                     fetch_ready,
  output logic [ISSUE_WIDTH-1:0]   issue_valid,
  output logic [64*ISSUE_WIDTH-1:0] issue_data,
  input  logic                     issue_ready,
  output logic                     jal,
  output logic [31:0]              jal_addr
`ifdef ISSUE_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_stall,
  output logic [31:0]              stat_split
`endif
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [CW-1:0] popcnt(input logic [ISSUE_WIDTH-1:0] m);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) n = n + CW'(m[i]);
    return n;
  endfunction

  function automatic logic [31:0] jal_target(input logic [31:0] instr, input logic [31:0] pc);
    logic [31:0] imm;
    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return pc + imm;
  endfunction

  logic [63:0]          q_mem [QDEPTH];
  logic [AW-1:0]        head, tail;
  logic [CW-1:0]        count;

  logic [ISSUE_WIDTH-1:0]    vld_p1;
  logic [64*ISSUE_WIDTH-1:0] data_p1;
  logic                      jal_p1;
  logic [31:0]               jal_addr_p1;

  logic [CW-1:0]             grp_n_p0;
  logic                      grp_jal_p0, grp_split_p0;
  logic [31:0]               grp_tgt_p0;
  logic [ISSUE_WIDTH-1:0]    vld_p0;
  logic [64*ISSUE_WIDTH-1:0] data_p0;

  logic                 scan_open;
  logic [31:0]          wr_mask;
  int                   ls_n;
  logic [63:0]          ent;
  logic [4:0]           rs1, rs2, rd;
  logic [6:0]           op;
  logic                 is_ls, raw, ls_full;

  logic                 load, jal_hit, enq;
  logic [CW-1:0]        enq_n;
  logic [AW-1:0]        head_new;

  assign fetch_ready = ((CW'(QDEPTH) - count) >= CW'(ISSUE_WIDTH)) && !jal_p1;
  assign enq         = fetch_valid && fetch_ready;
  assign enq_n       = popcnt(fetch_mask);
  assign load        = ((vld_p1 == '0) || issue_ready) && (count != '0);
  assign jal_hit     = load && grp_jal_p0;
  assign head_new    = head + grp_n_p0[AW-1:0];

  // Stage p0: scan from head, closing the group at the first hazard or after a JAL
  always_comb begin
    grp_n_p0     = '0;
    grp_jal_p0   = 1'b0;
    grp_split_p0 = 1'b0;
    grp_tgt_p0   = '0;
    vld_p0       = '0;
    data_p0      = '0;
    scan_open    = 1'b1;
    wr_mask      = '0;
    ls_n         = 0;
    ent          = '0;
    rs1          = '0;
    rs2          = '0;
    rd           = '0;
    op           = '0;
    is_ls        = 1'b0;
    raw          = 1'b0;
    ls_full      = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      ent     = q_mem[head + AW'(k)];
      rs1     = ent[51:47];
      rs2     = ent[56:52];
      rd      = ent[43:39];
      op      = ent[38:32];
      is_ls   = (op == OP_LOAD) || (op == OP_STORE);
      raw     = ((rs1 != '0) && wr_mask[rs1]) || ((rs2 != '0) && wr_mask[rs2]);
      ls_full = is_ls && (ls_n >= MAX_LS);
      if (scan_open && (CW'(k) < count)) begin
        if (raw || ls_full) begin
          scan_open    = 1'b0;
          grp_split_p0 = 1'b1;
        end else begin
          vld_p0[k]          = 1'b1;
          data_p0[64*k +: 64] = ent;
          grp_n_p0           = grp_n_p0 + CW'(1);
          if (is_ls) ls_n++;
          if ((op != OP_STORE) && (op != OP_BRANCH)) wr_mask[rd] = 1'b1;
          if (op == OP_JAL) begin
            scan_open  = 1'b0;
            grp_jal_p0 = 1'b1;
            grp_tgt_p0 = jal_target(ent[63:32], ent[31:0]);
          end
        end
      end
    end
  end

  // Queue storage carries no reset; occupancy is tracked by head/tail/count
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (fetch_mask[i]) q_mem[tail + AW'(i)] <= fetch_data[64*i +: 64];
      end
    end
  end

  // Stage p1: registered issue group and redirect pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      vld_p1      <= '0;
      data_p1     <= '0;
      jal_p1      <= 1'b0;
      jal_addr_p1 <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      vld_p1      <= '0;
      data_p1     <= '0;
      jal_p1      <= 1'b0;
      jal_addr_p1 <= '0;
    end else begin
      jal_p1      <= jal_hit;
      jal_addr_p1 <= jal_hit ? grp_tgt_p0 : '0;
      if (jal_hit) begin
        // Everything behind the JAL is wrong-path, including a bundle arriving this edge
        head  <= head_new;
        tail  <= head_new;
        count <= '0;
      end else begin
        if (load) head <= head_new;
        if (enq) tail <= tail + enq_n[AW-1:0];
        count <= count + (enq ? enq_n : '0) - (load ? grp_n_p0 : '0);
      end
      if (load) begin
        vld_p1  <= vld_p0;
        data_p1 <= data_p0;
      end else if (issue_ready) begin
        vld_p1  <= '0;
        data_p1 <= '0;
      end
    end
  end

  assign issue_valid = vld_p1;
  assign issue_data  = data_p1;
  assign jal         = jal_p1;
  assign jal_addr    = jal_addr_p1;

`ifdef ISSUE_SCHED_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
      stat_split  <= '0;
    end else begin
      if ((vld_p1 != '0) && issue_ready)
        stat_issued <= sat_add(stat_issued, 32'(popcnt(vld_p1)));
      if ((vld_p1 != '0) && !issue_ready)
        stat_stall <= sat_add(stat_stall, 32'd1);
      if (load && grp_split_p0 && !flush)
        stat_split <= sat_add(stat_split, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler (ISSUE_WIDTH=2, QDEPTH=8); a MAX_LS=2 copy runs in parallel.
module tb_issue_scheduler;

  logic         clk = 1'b0;
  logic         rst_n, flush, fetch_valid, issue_ready;
  logic [1:0]   fetch_mask;
  logic [127:0] fetch_data;

  logic         fetch_ready, jal, fetch_ready2, jal2;
  logic [1:0]   issue_valid, issue_valid2;
  logic [127:0] issue_data, issue_data2;
  logic [31:0]  jal_addr, jal_addr2;
`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0]  stat_issued, stat_stall, stat_split;
  logic [31:0]  stat_issued2, stat_stall2, stat_split2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.ISSUE_WIDTH(2), .QDEPTH(8), .MAX_LS(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_mask(fetch_mask), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .issue_valid(issue_valid), .issue_data(issue_data), .issue_ready(issue_ready),
    .jal(jal), .jal_addr(jal_addr)
`ifdef ISSUE_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall), .stat_split(stat_split)
`endif
  );

  issue_scheduler #(.ISSUE_WIDTH(2), .QDEPTH(8), .MAX_LS(2)) dut_ls2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_mask(fetch_mask), .fetch_data(fetch_data), .fetch_ready(fetch_ready2),
    .issue_valid(issue_valid2), .issue_data(issue_data2), .issue_ready(issue_ready),
    .jal(jal2), .jal_addr(jal_addr2)
`ifdef ISSUE_SCHED_STATS_EN
    , .stat_issued(stat_issued2), .stat_stall(stat_stall2), .stat_split(stat_split2)
`endif
  );

  function automatic logic [127:0] pk(input logic [31:0] i0, input logic [31:0] p0,
                                      input logic [31:0] i1, input logic [31:0] p1);
    return {i1, p1, i0, p0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [127:0] d);
    fetch_valid = 1'b1;
    fetch_mask  = m;
    fetch_data  = d;
  endtask

  localparam logic [31:0] ADDI5 = 32'h00100293;
  localparam logic [31:0] ADDI7 = 32'h00200393;
  localparam logic [31:0] ADD6  = 32'h00528333;
  localparam logic [31:0] LW1   = 32'h00012083;
  localparam logic [31:0] LW3   = 32'h00412183;
  localparam logic [31:0] JALI  = 32'h010000EF;
  localparam logic [31:0] NOP   = 32'h00000013;

  initial begin
    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_mask = '0;
    fetch_data = '0; issue_ready = 1'b0;
    #12;
    check("rst_valid", issue_valid, 0);
    check("rst_data", issue_data, 0);
    check("rst_jal", jal, 0);
    check("rst_jal_addr", jal_addr, 0);
    rst_n = 1'b1;
    tick();
    check("idle_fetch_ready", fetch_ready, 1);

    // Independent pair
    issue_ready = 1'b1;
    drive(2'b11, pk(ADDI5, 32'h100, ADDI7, 32'h104));
    tick();
    fetch_valid = 1'b0;
    check("pair_latency", issue_valid, 0);
    tick();
    check("pair_valid", issue_valid, 2'b11);
    check("pair_data", issue_data, pk(ADDI5, 32'h100, ADDI7, 32'h104));
    check("pair_jal", jal, 0);
    tick();
    check("pair_drain", issue_valid, 0);

    // RAW split
    drive(2'b11, pk(ADDI5, 32'h100, ADD6, 32'h104));
    tick();
    fetch_valid = 1'b0;
    tick();
    check("raw_g0_valid", issue_valid, 2'b01);
    check("raw_g0_data", issue_data, pk(ADDI5, 32'h100, 0, 0));
    tick();
    check("raw_g1_valid", issue_valid, 2'b01);
    check("raw_g1_data", issue_data, pk(ADD6, 32'h104, 0, 0));
`ifdef ISSUE_SCHED_STATS_EN
    check("raw_stat_split", stat_split, 1);
`endif
    tick();
    check("raw_drain", issue_valid, 0);

    // Load/store limit: MAX_LS=1 splits, MAX_LS=2 issues together
    drive(2'b11, pk(LW1, 32'h200, LW3, 32'h204));
    tick();
    fetch_valid = 1'b0;
    tick();
    check("ls1_g0_valid", issue_valid, 2'b01);
    check("ls1_g0_data", issue_data, pk(LW1, 32'h200, 0, 0));
    check("ls2_valid", issue_valid2, 2'b11);
    check("ls2_data", issue_data2, pk(LW1, 32'h200, LW3, 32'h204));
    check("ls2_jal", {jal2, jal_addr2}, 0);
    tick();
    check("ls1_g1_data", {issue_valid, issue_data}, {2'b01, pk(LW3, 32'h204, 0, 0)});
    check("ls2_drain", issue_valid2, 0);
    check("ls2_fetch_ready", fetch_ready2, 1);
    tick();
    check("ls1_drain", issue_valid, 0);

    // JAL squash with a younger bundle already queued behind it
    issue_ready = 1'b0;
    drive(2'b11, pk(ADDI5, 32'h300, ADDI7, 32'h304));
    tick();
    drive(2'b11, pk(JALI, 32'h100, ADDI7, 32'h104));
    tick();
    check("jal_hold_valid", issue_valid, 2'b11);
    check("jal_hold_data", issue_data, pk(ADDI5, 32'h300, ADDI7, 32'h304));
    drive(2'b11, pk(ADDI5, 32'h108, ADDI7, 32'h10C));
    tick();
    fetch_valid = 1'b0;
    check("jal_hold2_data", issue_data, pk(ADDI5, 32'h300, ADDI7, 32'h304));
    issue_ready = 1'b1;
    tick();
    check("jal_grp_valid", issue_valid, 2'b01);
    check("jal_grp_data", issue_data, pk(JALI, 32'h100, 0, 0));
    check("jal_pulse", jal, 1);
    check("jal_target", jal_addr, 32'h110);
    check("jal_fetch_ready", fetch_ready, 0);
    tick();
    check("jal_pulse_end", jal, 0);
    check("jal_addr_clear", jal_addr, 0);
    check("jal_squash_valid", issue_valid, 0);
    check("jal_fetch_ready_back", fetch_ready, 1);
    tick();
    check("jal_squash_empty", issue_valid, 0);

    // Backpressure and full queue
    issue_ready = 1'b0;
    drive(2'b11, pk(NOP, 32'h400, NOP, 32'h404));
    tick();
    drive(2'b11, pk(NOP, 32'h408, NOP, 32'h40C));
    tick();
    check("bp_b0", {issue_valid, issue_data}, {2'b11, pk(NOP, 32'h400, NOP, 32'h404)});
    drive(2'b11, pk(NOP, 32'h410, NOP, 32'h414));
    tick();
    drive(2'b11, pk(NOP, 32'h418, NOP, 32'h41C));
    tick();
    check("bp_ready_at6", fetch_ready, 1);
    drive(2'b01, pk(NOP, 32'h420, 0, 0));
    tick();
    check("bp_ready_at7", fetch_ready, 0);
    drive(2'b11, pk(NOP, 32'h500, NOP, 32'h504));
    tick();
    fetch_valid = 1'b0;
    check("bp_hold", {issue_valid, issue_data}, {2'b11, pk(NOP, 32'h400, NOP, 32'h404)});
    issue_ready = 1'b1;
    tick();
    check("bp_d1", {issue_valid, issue_data}, {2'b11, pk(NOP, 32'h408, NOP, 32'h40C)});
    check("bp_ready_after_drain", fetch_ready, 1);
    tick();
    check("bp_d2", {issue_valid, issue_data}, {2'b11, pk(NOP, 32'h410, NOP, 32'h414)});
    tick();
    check("bp_d3", {issue_valid, issue_data}, {2'b11, pk(NOP, 32'h418, NOP, 32'h41C)});
    tick();
    check("bp_d4", {issue_valid, issue_data}, {2'b01, pk(NOP, 32'h420, 0, 0)});
    tick();
    check("bp_empty", issue_valid, 0);

    // Flush on the edge a JAL group would load
    drive(2'b11, pk(JALI, 32'h100, ADDI7, 32'h104));
    tick();
    fetch_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_jal", jal, 0);
    check("flush_jal_addr", jal_addr, 0);
    check("flush_valid", issue_valid, 0);
    tick();
    check("flush_empty", issue_valid, 0);
    check("flush_fetch_ready", fetch_ready, 1);

    // Asynchronous reset mid-stream
    issue_ready = 1'b0;
    drive(2'b11, pk(NOP, 32'h600, NOP, 32'h604));
    tick();
    drive(2'b11, pk(NOP, 32'h608, NOP, 32'h60C));
    tick();
    fetch_valid = 1'b0;
    check("mid_pre_valid", issue_valid, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", issue_valid, 0);
    check("mid_rst_data", issue_data, 0);
    check("mid_rst_jal", {jal, jal_addr}, 0);
    #2;
    rst_n = 1'b1;
    issue_ready = 1'b1;
    tick();
    check("mid_post_empty", issue_valid, 0);
    check("mid_post_ready", fetch_ready, 1);
    tick();
    check("mid_post_empty2", issue_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
